// File: rtl/parc_mem_port_arbiter_pkg.sv
// Shared memory-message encodings for the PARCv2 memory port arbiter.
// Type/len values match the core's mem request format; tag marks the owner of an in-flight request.
package parc_mem_port_arbiter_pkg;

  localparam logic       MEM_TYPE_READ  = 1'b0;
  localparam logic       MEM_TYPE_WRITE = 1'b1;

  localparam logic [1:0] MEM_LEN_WORD   = 2'd0;
  localparam logic [1:0] MEM_LEN_BYTE   = 2'd1;
  localparam logic [1:0] MEM_LEN_HALF   = 2'd2;

  typedef enum logic {
    TAG_IMEM = 1'b0,
    TAG_DMEM = 1'b1
  } mem_tag_e;

endpackage

// File: rtl/parc_mem_arb_tag_fifo.sv
// In-order owner-tag FIFO; push/pop take effect on the next edge, head and count are registered.
// No internal backpressure: push when full and pop when empty are ignored.
module parc_mem_arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     push_dat_i,
  input  logic                     pop_i,
  output logic                     head_dat_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] mem_q,    mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push,  do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/parc_mem_port_arbiter.sv
// Shares one memory port between imem and dmem: 0-cycle request grant and response routing.
// Dmem wins conflicts until imem starves; a stalled request is locked until it fires; issue stops at MAX_INFLIGHT.
module parc_mem_port_arbiter
  import parc_mem_port_arbiter_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            imemreq_val,
  output logic                            imemreq_rdy,
  input  logic [31:0]                     imemreq_msg_addr,
  output logic                            imemresp_val,
  input  logic                            imemresp_rdy,
  output logic [31:0]                     imemresp_msg_data,
  input  logic                            dmemreq_val,
  output logic                            dmemreq_rdy,
  input  logic                            dmemreq_msg_type,
  input  logic [1:0]                      dmemreq_msg_len,
  input  logic [31:0]                     dmemreq_msg_addr,
  input  logic [31:0]                     dmemreq_msg_data,
  output logic                            dmemresp_val,
  input  logic                            dmemresp_rdy,
  output logic [31:0]                     dmemresp_msg_data,
  output logic                            memreq_val,
  input  logic                            memreq_rdy,
  output logic                            memreq_msg_type,
  output logic [1:0]                      memreq_msg_len,
  output logic [31:0]                     memreq_msg_addr,
  output logic [31:0]                     memreq_msg_data,
  input  logic                            memresp_val,
  output logic                            memresp_rdy,
  input  logic [31:0]                     memresp_msg_data,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight_count,
  output logic                            err_unexp_resp
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  mem_tag_e        sel_src;
  mem_tag_e        lock_src_q, lock_src_d;
  logic            lock_vld_q, lock_vld_d;
  logic [SW-1:0]   starve_q,   starve_d;
  logic            err_q,      err_d;
  logic            can_issue, sel_val, req_fire, resp_fire;
  logic            fifo_empty, fifo_full, head_tag;

  assign can_issue = (inflight_count < CW'(MAX_INFLIGHT));

  always_comb begin
    sel_src = TAG_DMEM;
    if (lock_vld_q) begin
      sel_src = lock_src_q;
    end else if (imemreq_val && dmemreq_val) begin
      sel_src = (starve_q == SW'(STARVE_LIMIT)) ? TAG_IMEM : TAG_DMEM;
    end else if (imemreq_val) begin
      sel_src = TAG_IMEM;
    end
  end

  assign sel_val     = (sel_src == TAG_IMEM) ? imemreq_val : dmemreq_val;
  assign memreq_val  = can_issue && sel_val;
  assign imemreq_rdy = (sel_src == TAG_IMEM) && imemreq_val && can_issue && memreq_rdy;
  assign dmemreq_rdy = (sel_src == TAG_DMEM) && dmemreq_val && can_issue && memreq_rdy;
  assign req_fire    = memreq_val && memreq_rdy;

  always_comb begin
    memreq_msg_type = dmemreq_msg_type;
    memreq_msg_len  = dmemreq_msg_len;
    memreq_msg_addr = dmemreq_msg_addr;
    memreq_msg_data = dmemreq_msg_data;
    if (sel_src == TAG_IMEM) begin
      memreq_msg_type = MEM_TYPE_READ;
      memreq_msg_len  = MEM_LEN_WORD;
      memreq_msg_addr = imemreq_msg_addr;
      memreq_msg_data = '0;
    end
  end

  // Lock keeps a stalled request on the port so val/rdy stays stable across a conflict.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_src_d = lock_src_q;
    starve_d   = starve_q;
    if (req_fire) begin
      lock_vld_d = 1'b0;
    end else if (memreq_val) begin
      lock_vld_d = 1'b1;
      lock_src_d = sel_src;
    end
    if (!imemreq_val || (req_fire && sel_src == TAG_IMEM)) begin
      starve_d = '0;
    end else if (req_fire && sel_src == TAG_DMEM && starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  assign imemresp_val      = memresp_val && !fifo_empty && (head_tag == TAG_IMEM);
  assign dmemresp_val      = memresp_val && !fifo_empty && (head_tag == TAG_DMEM);
  assign imemresp_msg_data = memresp_msg_data;
  assign dmemresp_msg_data = memresp_msg_data;
  assign memresp_rdy       = !fifo_empty && ((head_tag == TAG_IMEM) ? imemresp_rdy : dmemresp_rdy);
  assign resp_fire         = memresp_val && memresp_rdy;

  assign err_d          = err_q || (memresp_val && fifo_empty);
  assign err_unexp_resp = err_q;

  parc_mem_arb_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (req_fire),
    .push_dat_i (sel_src),
    .pop_i      (resp_fire),
    .head_dat_o (head_tag),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .count_o    (inflight_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_vld_q <= 1'b0;
      lock_src_q <= TAG_IMEM;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_src_q <= lock_src_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_parc_mem_port_arbiter.sv
// Bench for parc_mem_port_arbiter: in-order memory model plus per-requester expected-response queues.
module tb_parc_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemreq_val, imemreq_rdy;
  logic [31:0] imemreq_msg_addr;
  logic        imemresp_val, imemresp_rdy;
  logic [31:0] imemresp_msg_data;
  logic        dmemreq_val, dmemreq_rdy;
  logic        dmemreq_msg_type;
  logic [1:0]  dmemreq_msg_len;
  logic [31:0] dmemreq_msg_addr, dmemreq_msg_data;
  logic        dmemresp_val, dmemresp_rdy;
  logic [31:0] dmemresp_msg_data;
  logic        memreq_val, memreq_rdy;
  logic        memreq_msg_type;
  logic [1:0]  memreq_msg_len;
  logic [31:0] memreq_msg_addr, memreq_msg_data;
  logic        memresp_val, memresp_rdy;
  logic [31:0] memresp_msg_data;
  logic [2:0]  inflight_count;
  logic        err_unexp_resp;

  int total = 0;
  int bad   = 0;

  logic [31:0] data_q[$];   // response data to hand out for upcoming fires
  logic [31:0] mem_q[$];    // memory model: responses owed, in issue order
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  bit          fire_log[$]; // 0 = imem fire, 1 = dmem fire
  logic [31:0] mdat;
  bit          dresp_seen = 0;
  bit          stall_prev = 0;

  parc_mem_port_arbiter #(.MAX_INFLIGHT(4), .STARVE_LIMIT(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .imemreq_val       (imemreq_val),
    .imemreq_rdy       (imemreq_rdy),
    .imemreq_msg_addr  (imemreq_msg_addr),
    .imemresp_val      (imemresp_val),
    .imemresp_rdy      (imemresp_rdy),
    .imemresp_msg_data (imemresp_msg_data),
    .dmemreq_val       (dmemreq_val),
    .dmemreq_rdy       (dmemreq_rdy),
    .dmemreq_msg_type  (dmemreq_msg_type),
    .dmemreq_msg_len   (dmemreq_msg_len),
    .dmemreq_msg_addr  (dmemreq_msg_addr),
    .dmemreq_msg_data  (dmemreq_msg_data),
    .dmemresp_val      (dmemresp_val),
    .dmemresp_rdy      (dmemresp_rdy),
    .dmemresp_msg_data (dmemresp_msg_data),
    .memreq_val        (memreq_val),
    .memreq_rdy        (memreq_rdy),
    .memreq_msg_type   (memreq_msg_type),
    .memreq_msg_len    (memreq_msg_len),
    .memreq_msg_addr   (memreq_msg_addr),
    .memreq_msg_data   (memreq_msg_data),
    .memresp_val       (memresp_val),
    .memresp_rdy       (memresp_rdy),
    .memresp_msg_data  (memresp_msg_data),
    .inflight_count    (inflight_count),
    .err_unexp_resp    (err_unexp_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_resp();
    imemresp_rdy     = 1'b1;
    dmemresp_rdy     = 1'b1;
    memresp_val      = (mem_q.size() != 0);
    memresp_msg_data = (mem_q.size() != 0) ? mem_q[0] : 32'h0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (inflight_count != 0 || mem_q.size() != 0); i++) begin
      drive_resp();
      @(negedge clk);
      tick();
    end
    memresp_val = 1'b0;
    @(negedge clk);
    chk("drain_inflight", inflight_count, 0);
    tick();
  endtask

  // Scoreboard side: log fires, feed the memory model, check routed responses.
  always @(negedge clk) begin
    if (reset) begin
      if (memreq_val && memreq_rdy) begin
        mdat = (data_q.size() != 0) ? data_q.pop_front() : (memreq_msg_addr ^ 32'h5A5A_0000);
        mem_q.push_back(mdat);
        if (imemreq_val && imemreq_rdy) begin
          fire_log.push_back(1'b0);
          exp_i_q.push_back(mdat);
        end else begin
          fire_log.push_back(1'b1);
          exp_d_q.push_back(mdat);
        end
      end
      if (memresp_val && memresp_rdy && mem_q.size() != 0) void'(mem_q.pop_front());
      if (imemresp_val && imemresp_rdy) begin
        if (exp_i_q.size() == 0) chk("imem_resp_unexp", 1, 0);
        else chk("imem_resp", imemresp_msg_data, exp_i_q.pop_front());
      end
      if (dmemresp_val) dresp_seen = 1;
      if (dmemresp_val && dmemresp_rdy) begin
        if (exp_d_q.size() == 0) chk("dmem_resp_unexp", 1, 0);
        else chk("dmem_resp", dmemresp_msg_data, exp_d_q.pop_front());
      end
      if (stall_prev) chk("lock_keep_val", memreq_val, 1);
      stall_prev = memreq_val && !memreq_rdy;
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    imemreq_val = 0; imemreq_msg_addr = 0; imemresp_rdy = 0;
    dmemreq_val = 0; dmemreq_msg_type = 0; dmemreq_msg_len = 0;
    dmemreq_msg_addr = 0; dmemreq_msg_data = 0; dmemresp_rdy = 0;
    memreq_rdy = 0; memresp_val = 0; memresp_msg_data = 0;
    #2;
    chk("rst_memreq_val", memreq_val, 0);
    chk("rst_irdy", imemreq_rdy, 0);
    chk("rst_drdy", dmemreq_rdy, 0);
    chk("rst_iresp_val", imemresp_val, 0);
    chk("rst_dresp_val", dmemresp_val, 0);
    chk("rst_memresp_rdy", memresp_rdy, 0);
    chk("rst_inflight", inflight_count, 0);
    chk("rst_err", err_unexp_resp, 0);
    tick();
    reset = 1'b1;
    memreq_rdy = 1'b1;
    @(negedge clk);
    chk("idle_irdy", imemreq_rdy, 0);
    chk("idle_drdy", dmemreq_rdy, 0);
    chk("idle_memreq_val", memreq_val, 0);
    tick();

    // Imem-only read, memory answers 3 cycles later
    data_q.push_back(32'h2402000A);
    imemreq_val = 1; imemreq_msg_addr = 32'h0008_0000;
    @(negedge clk);
    chk("t1_val", memreq_val, 1);
    chk("t1_addr", memreq_msg_addr, 32'h0008_0000);
    chk("t1_type", memreq_msg_type, 0);
    chk("t1_len", memreq_msg_len, 0);
    chk("t1_data", memreq_msg_data, 0);
    chk("t1_irdy", imemreq_rdy, 1);
    tick();
    imemreq_val = 0;
    @(negedge clk);
    chk("t1_inflight", inflight_count, 1);
    tick();
    tick();
    imemresp_rdy = 1; memresp_val = 1; memresp_msg_data = mem_q.size() != 0 ? mem_q[0] : 32'h0;
    @(negedge clk);
    chk("t1_memresp_rdy", memresp_rdy, 1);
    chk("t1_iresp_val", imemresp_val, 1);
    chk("t1_iresp_data", imemresp_msg_data, 32'h2402000A);
    tick();
    memresp_val = 0;
    @(negedge clk);
    chk("t1_inflight_end", inflight_count, 0);
    chk("t1_no_dresp", dresp_seen, 0);
    tick();

    // Conflict: 8 dmem wins, then a forced imem grant, repeating
    fire_log.delete();
    imemreq_val = 1; imemreq_msg_addr = 32'h0000_0100;
    dmemreq_val = 1; dmemreq_msg_addr = 32'h0000_0200; dmemreq_msg_type = 0;
    for (int c = 0; c < 300 && fire_log.size() < 18; c++) begin
      drive_resp();
      @(negedge clk);
      tick();
    end
    imemreq_val = 0; dmemreq_val = 0;
    chk("conf_nfires", fire_log.size(), 18);
    for (int i = 0; i < 18; i++) begin
      if (i < fire_log.size()) chk($sformatf("conf_src%0d", i), fire_log[i], (i % 9 == 8) ? 0 : 1);
    end
    drain();

    // Lock: stalled imem request holds the port while dmem shows up
    fire_log.delete();
    memreq_rdy = 0;
    imemreq_val = 1; imemreq_msg_addr = 32'h0000_0300;
    @(negedge clk);
    chk("lk_val0", memreq_val, 1);
    chk("lk_addr0", memreq_msg_addr, 32'h0000_0300);
    tick();
    dmemreq_val = 1; dmemreq_msg_addr = 32'h0000_0400;
    @(negedge clk);
    chk("lk_addr1", memreq_msg_addr, 32'h0000_0300);
    chk("lk_drdy1", dmemreq_rdy, 0);
    tick();
    @(negedge clk);
    chk("lk_addr2", memreq_msg_addr, 32'h0000_0300);
    tick();
    memreq_rdy = 1;
    @(negedge clk);
    chk("lk_addr3", memreq_msg_addr, 32'h0000_0300);
    chk("lk_irdy3", imemreq_rdy, 1);
    tick();
    imemreq_val = 0;
    @(negedge clk);
    chk("lk_drdy4", dmemreq_rdy, 1);
    tick();
    dmemreq_val = 0;
    chk("lk_nfires", fire_log.size(), 2);
    if (fire_log.size() >= 2) begin
      chk("lk_first", fire_log[0], 0);
      chk("lk_second", fire_log[1], 1);
    end
    drain();

    // Full: four fires with responses withheld, then credit returns a cycle late
    memresp_val = 0;
    for (int k = 0; k < 4; k++) begin
      dmemreq_val = 1; dmemreq_msg_addr = 32'h0000_1000 + 32'(4 * k);
      @(negedge clk);
      chk("full_fire", dmemreq_rdy, 1);
      tick();
    end
    dmemreq_msg_addr = 32'h0000_1010;
    @(negedge clk);
    chk("full_count", inflight_count, 4);
    chk("full_val", memreq_val, 0);
    tick();
    dmemresp_rdy = 1; memresp_val = 1; memresp_msg_data = mem_q.size() != 0 ? mem_q[0] : 32'h0;
    @(negedge clk);
    chk("full_pop_rdy", memresp_rdy, 1);
    chk("full_no_same_cycle", memreq_val, 0);
    tick();
    memresp_val = 0;
    @(negedge clk);
    chk("full_count3", inflight_count, 3);
    chk("full_reissue", memreq_val, 1);
    tick();
    dmemreq_val = 0;
    drain();

    // Ordering I, D, I with dmem response backpressure
    data_q.push_back(32'h11); data_q.push_back(32'h22); data_q.push_back(32'h33);
    imemreq_val = 1; imemreq_msg_addr = 32'h0000_0500;
    tick();
    imemreq_val = 0; dmemreq_val = 1; dmemreq_msg_addr = 32'h0000_0600;
    tick();
    dmemreq_val = 0; imemreq_val = 1; imemreq_msg_addr = 32'h0000_0504;
    tick();
    imemreq_val = 0;
    imemresp_rdy = 1; dmemresp_rdy = 1; memresp_val = 1;
    memresp_msg_data = mem_q.size() != 0 ? mem_q[0] : 32'h0;
    @(negedge clk);
    chk("o1_ival", imemresp_val, 1);
    chk("o1_idata", imemresp_msg_data, 32'h11);
    tick();
    dmemresp_rdy = 0; memresp_msg_data = mem_q.size() != 0 ? mem_q[0] : 32'h0;
    @(negedge clk);
    chk("o2_mrdy", memresp_rdy, 0);
    chk("o2_dval", dmemresp_val, 1);
    chk("o2_ival", imemresp_val, 0);
    tick();
    @(negedge clk);
    chk("o3_mrdy", memresp_rdy, 0);
    tick();
    dmemresp_rdy = 1;
    @(negedge clk);
    chk("o4_mrdy", memresp_rdy, 1);
    chk("o4_ddata", dmemresp_msg_data, 32'h22);
    tick();
    memresp_msg_data = mem_q.size() != 0 ? mem_q[0] : 32'h0;
    @(negedge clk);
    chk("o5_ival", imemresp_val, 1);
    chk("o5_idata", imemresp_msg_data, 32'h33);
    tick();
    memresp_val = 0;
    @(negedge clk);
    chk("o_inflight", inflight_count, 0);
    chk("o_exp_left", exp_i_q.size() + exp_d_q.size(), 0);
    tick();

    // Unexpected response, then asynchronous reset with two requests in flight
    memresp_val = 1; memresp_msg_data = 32'hDEAD_0000;
    @(negedge clk);
    chk("ux_mrdy", memresp_rdy, 0);
    chk("ux_ival", imemresp_val, 0);
    chk("ux_dval", dmemresp_val, 0);
    chk("ux_err_before", err_unexp_resp, 0);
    tick();
    memresp_val = 0;
    @(negedge clk);
    chk("ux_err_set", err_unexp_resp, 1);
    tick();
    imemreq_val = 1; imemreq_msg_addr = 32'h0000_0700;
    tick();
    imemreq_msg_addr = 32'h0000_0704;
    tick();
    imemreq_val = 0;
    @(negedge clk);
    chk("rb_inflight2", inflight_count, 2);
    chk("rb_err_held", err_unexp_resp, 1);
    #2;
    reset = 0;
    #1;
    chk("rb_async_inflight", inflight_count, 0);
    chk("rb_async_err", err_unexp_resp, 0);
    mem_q.delete(); exp_i_q.delete(); exp_d_q.delete(); data_q.delete();
    tick();
    tick();
    reset = 1;
    @(negedge clk);
    chk("rb_post_inflight", inflight_count, 0);
    chk("rb_post_val", memreq_val, 0);
    chk("rb_post_err", err_unexp_resp, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
